// File: rtl/div_hilo_unit.sv
// div_hilo_unit: multi-cycle MIPS DIV/DIVU unit with HI/LO registers
// Restoring shift-subtract divider, one quotient bit per cycle.
// Quotient goes to LO and remainder to HI; MTHI/MTLO writes are accepted while idle.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, is_signed   divide request and DIV(1)/DIVU(0) select, sampled in IDLE
//   A, B               dividend, divisor
//   wr_hi, wr_lo       MTHI/MTLO strobes carrying wr_data
//   busy, done         stall indicator, one-cycle completion pulse
//   div_by_zero        divide-by-zero pulse (only with DIV_ZERO_TRAP_EN)
//   hi, lo             remainder, quotient
// Optional: define DIV_ZERO_TRAP_EN to short-circuit B==0 into a div_by_zero pulse.
module div_hilo_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] r_q, r_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic sa_q, sa_d, sb_q, sb_d, ge;
  logic [W:0] t, diff;
`ifdef DIV_ZERO_TRAP_EN
  logic dz_q, dz_d;
`endif
  // full W+1-bit partial remainder so large unsigned divisors stay exact
  assign t    = {r_q, q_q[W-1]};
  assign diff = t - {1'b0, b_q};
  assign ge   = t >= {1'b0, b_q};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef DIV_ZERO_TRAP_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
`ifdef DIV_ZERO_TRAP_EN
        // a trapped divide waits one idle cycle so done lands two cycles after start
        if (dz_q) state_d = DONE;
        else if (start && B == '0) dz_d = 1'b1;
        else if (start) begin
`else
        if (start) begin
`endif
          sa_d    = is_signed & A[W-1];
          sb_d    = is_signed & B[W-1];
          q_d     = sa_d ? -A : A;
          b_d     = sb_d ? -B : B;
          r_d     = '0;
          cnt_d   = CW'(W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        q_d     = {q_q[W-2:0], ge};
        r_d     = ge ? diff[W-1:0] : t[W-1:0];
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? FIX : RUN;
      end
      FIX: begin
        lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
        hi_d    = sa_q ? -r_q : r_q;
        state_d = DONE;
      end
      default: begin
`ifdef DIV_ZERO_TRAP_EN
        dz_d    = 1'b0;
`endif
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef DIV_ZERO_TRAP_EN
      dz_q    <= dz_d;
`endif
    end
  end
  assign busy = state_q == RUN || state_q == FIX;
  assign done = state_q == DONE;
`ifdef DIV_ZERO_TRAP_EN
  assign div_by_zero = done & dz_q;
`else
  assign div_by_zero = 1'b0;
`endif
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_div_hilo_unit.sv
// tb_div_hilo_unit: directed checks of div_hilo_unit (default build, W=8)
module tb_div_hilo_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
  logic [7:0] A = '0, B = '0, wr_data = '0;
  logic wr_hi = 1'b0, wr_lo = 1'b0;
  logic busy, done, div_by_zero;
  logic [7:0] hi, lo;
  int pass_cnt = 0, total = 0;

  div_hilo_unit #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .A(A), .B(B),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", div_by_zero); else pass_cnt++;
    total++; if (hi !== 8'h00) $display("FAIL reset_hi got %h want 00", hi); else pass_cnt++;
    total++; if (lo !== 8'h00) $display("FAIL reset_lo got %h want 00", lo); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // start at edge 0; busy expected in cycles 1..9, done in cycle 10.
  // inj>0 pulses a second start plus wr_lo=0xAA during cycle inj.
  task automatic run_op(input string nm, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input int inj, input logic [7:0] exp_lo, input logic [7:0] exp_hi);
    int dc;
    bit busy_bad;
    logic [7:0] lo_s, hi_s;
    logic dz_s;
    dc = 0; busy_bad = 0; lo_s = 'x; hi_s = 'x; dz_s = 'x;
    @(negedge clk);
    start = 1'b1; is_signed = s; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      @(negedge clk);
      if (busy !== (c <= 9)) busy_bad = 1;
      if (done === 1'b1) begin dc = c; lo_s = lo; hi_s = hi; dz_s = div_by_zero; end
      start = 1'b0; wr_lo = 1'b0;
      if (c == inj) begin start = 1'b1; is_signed = 1'b0; A = 8'h11; B = 8'h03; wr_lo = 1'b1; wr_data = 8'hAA; end
    end
    start = 1'b0; wr_lo = 1'b0;
    total++; if (busy_bad) $display("FAIL %s_busy busy profile wrong, want high cycles 1-9", nm); else pass_cnt++;
    total++; if (dc != 10) $display("FAIL %s_latency done cycle got %0d want 10", nm, dc); else pass_cnt++;
    total++; if (lo_s !== exp_lo) $display("FAIL %s_lo got %h want %h", nm, lo_s, exp_lo); else pass_cnt++;
    total++; if (hi_s !== exp_hi) $display("FAIL %s_hi got %h want %h", nm, hi_s, exp_hi); else pass_cnt++;
    total++; if (dz_s !== 1'b0) $display("FAIL %s_dz got %b want 0", nm, dz_s); else pass_cnt++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL %s_done_pulse got %b want 0", nm, done); else pass_cnt++;
  endtask

  task automatic test_unsigned();
    run_op("u100_7", 1'b0, 8'd100, 8'd7, 0, 8'h0E, 8'h02);
    run_op("u200_201", 1'b0, 8'd200, 8'd201, 0, 8'h00, 8'hC8);
    run_op("u255_16", 1'b0, 8'd255, 8'd16, 0, 8'h0F, 8'h0F);
  endtask

  task automatic test_signed();
    run_op("s_m7_2", 1'b1, 8'hF9, 8'h02, 0, 8'hFD, 8'hFF);
    run_op("s_7_m2", 1'b1, 8'h07, 8'hFE, 0, 8'hFD, 8'h01);
    run_op("s_m128_m1", 1'b1, 8'h80, 8'hFF, 0, 8'h80, 8'h00);
  endtask

  task automatic test_div_zero();
    run_op("u_div0", 1'b0, 8'h35, 8'h00, 0, 8'hFF, 8'h35);
    run_op("s_div0", 1'b1, 8'hF9, 8'h00, 0, 8'h01, 8'hF9);
  endtask

  task automatic test_ignored();
    run_op("ignored", 1'b0, 8'd100, 8'd7, 4, 8'h0E, 8'h02);
  endtask

  task automatic test_mt();
    @(negedge clk);
    wr_hi = 1'b1; wr_data = 8'h5A;
    @(posedge clk);
    #1 wr_hi = 1'b0;
    total++; if (hi !== 8'h5A) $display("FAIL mthi_hi got %h want 5a", hi); else pass_cnt++;
    total++; if (lo !== 8'h0E) $display("FAIL mthi_lo got %h want 0e", lo); else pass_cnt++;
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 8'h3C;
    @(posedge clk);
    #1 wr_hi = 1'b0; wr_lo = 1'b0;
    total++; if (hi !== 8'h3C) $display("FAIL mtboth_hi got %h want 3c", hi); else pass_cnt++;
    total++; if (lo !== 8'h3C) $display("FAIL mtboth_lo got %h want 3c", lo); else pass_cnt++;
  endtask

  task automatic test_rst_abort();
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; A = 8'd100; B = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else pass_cnt++;
    total++; if (hi !== 8'h00) $display("FAIL abort_hi got %h want 00", hi); else pass_cnt++;
    total++; if (lo !== 8'h00) $display("FAIL abort_lo got %h want 00", lo); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
    end
    total++; if (saw_done) $display("FAIL abort_quiet activity after aborted op got 1 want 0"); else pass_cnt++;
    run_op("after_abort", 1'b0, 8'd9, 8'd3, 0, 8'h03, 8'h00);
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [7:0] lo1, hi1, lo2, hi2;
    logic b14;
    d1 = 0; d2 = 0; lo1 = 'x; hi1 = 'x; lo2 = 'x; hi2 = 'x; b14 = 'x;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; A = 8'd100; B = 8'd7;
    @(posedge clk);
    for (int c = 1; c <= 30 && d2 == 0; c++) begin
      @(negedge clk);
      if (done === 1'b1 && d1 == 0) begin d1 = c; lo1 = lo; hi1 = hi; end
      else if (done === 1'b1) begin d2 = c; lo2 = lo; hi2 = hi; end
      if (c == 14) b14 = busy;
      if (c == 1) begin is_signed = 1'b1; A = 8'hF9; B = 8'h02; end
      if (c == 14) start = 1'b0;
    end
    start = 1'b0;
    total++; if (d1 != 10) $display("FAIL b2b_first_latency got %0d want 10", d1); else pass_cnt++;
    total++; if (lo1 !== 8'h0E || hi1 !== 8'h02) $display("FAIL b2b_first_result got lo=%h hi=%h want lo=0e hi=02", lo1, hi1); else pass_cnt++;
    total++; if (b14 !== 1'b1) $display("FAIL b2b_second_busy got %b want 1", b14); else pass_cnt++;
    total++; if (d2 != 21) $display("FAIL b2b_second_latency got %0d want 21", d2); else pass_cnt++;
    total++; if (lo2 !== 8'hFD || hi2 !== 8'hFF) $display("FAIL b2b_second_result got lo=%h hi=%h want lo=fd hi=ff", lo2, hi2); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignored();
    test_mt();
    test_rst_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
